// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, reset PC, bubble encoding and FSM states for the fetch stage.
package fetch_stage_pkg;
   localparam int XLEN = 32;
   typedef logic [XLEN-1:0] word_t;
   localparam word_t RESET_PC = 32'h0000_0000;
   localparam word_t NOP_INSTR = 32'h0000_0000;
   typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DISCARD = 2'd2} fetch_state_e;
   function automatic word_t word_align(word_t a);
      return {a[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard/redirect controls, instruction-memory handshake and IF/ID outputs.
interface fetch_stage_if;
   import fetch_stage_pkg::*;
   logic stall, flush, jump, branch_taken, imem_req, imem_ack, valid;
   word_t jump_target, branch_target, imem_addr, imem_data, instr, pc_plus4;
   logic [5:0] opcode, funct;
   modport master(
      output stall, flush, jump, jump_target, branch_taken, branch_target, imem_ack, imem_data,
      input imem_req, imem_addr, instr, pc_plus4, valid, opcode, funct
   );
   modport slave(
      input stall, flush, jump, jump_target, branch_taken, branch_target, imem_ack, imem_data,
      output imem_req, imem_addr, instr, pc_plus4, valid, opcode, funct
   );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter with async reset, hold, +4 and word-aligned target load.
module pc_reg
   import fetch_stage_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  load_i,
   input  logic  inc_i,
   input  word_t target_i,
   output word_t pc_o
);
   word_t pc_q, pc_d;
   always_comb pc_d = load_i ? word_align(target_i) : inc_i ? pc_q + 32'd4 : pc_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) pc_q <= RESET_PC;
      else pc_q <= pc_d;
   assign pc_o = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with hold buffer, redirect discard and IF/ID register.
// Define FETCH_STATS_EN to add the fetch_count port counting delivered instructions.
module fetch_stage
   import fetch_stage_pkg::*;
(
   input logic clk,
   input logic reset,
   fetch_stage_if.slave bus
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] fetch_count
`endif
);
   fetch_state_e state_q, state_d;
   logic run_q, valid_q, valid_d, req, ack, redir, fill, pc_load, pc_inc;
   word_t pc, pc_tgt, redir_tgt, fill_word, hold_q, hold_d, tgt_q, tgt_d;
   word_t instr_q, instr_d, pp4_q, pp4_d;
   assign redir = bus.jump | bus.branch_taken;
   assign redir_tgt = word_align(bus.jump ? bus.jump_target : bus.branch_target);
   // DISCARD keeps the cancelled request on the bus so its address stays stable until ack
   assign req = run_q & (state_q != HOLD);
   assign ack = bus.imem_ack & req;
   always_comb begin
      state_d = state_q;
      hold_d = hold_q;
      tgt_d = tgt_q;
      pc_load = 1'b0;
      pc_inc = 1'b0;
      pc_tgt = redir_tgt;
      fill = 1'b0;
      fill_word = bus.imem_data;
      if (redir) begin
         if (req & ~ack) begin
            tgt_d = redir_tgt;
            state_d = DISCARD;
         end else begin
            pc_load = 1'b1;
            hold_d = NOP_INSTR;
            state_d = FETCH;
         end
      end else if (state_q == FETCH) begin
         if (ack & bus.stall) begin
            hold_d = bus.imem_data;
            state_d = HOLD;
         end else if (ack) begin
            pc_inc = 1'b1;
            fill = 1'b1;
         end
      end else if (state_q == HOLD) begin
         if (~bus.stall) begin
            pc_inc = 1'b1;
            fill = 1'b1;
            fill_word = hold_q;
            hold_d = NOP_INSTR;
            state_d = FETCH;
         end
      end else if (ack) begin
         pc_load = 1'b1;
         pc_tgt = tgt_q;
         state_d = FETCH;
      end
      instr_d = instr_q;
      pp4_d = pp4_q;
      valid_d = valid_q;
      if (redir | bus.flush | (~fill & ~bus.stall)) begin
         instr_d = NOP_INSTR;
         pp4_d = '0;
         valid_d = 1'b0;
      end else if (fill) begin
         instr_d = fill_word;
         pp4_d = pc + 32'd4;
         valid_d = 1'b1;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= FETCH;
         run_q <= 1'b0;
         hold_q <= NOP_INSTR;
         tgt_q <= '0;
         instr_q <= NOP_INSTR;
         pp4_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q <= 1'b1;
         hold_q <= hold_d;
         tgt_q <= tgt_d;
         instr_q <= instr_d;
         pp4_q <= pp4_d;
         valid_q <= valid_d;
      end
   pc_reg u_pc (
      .clk(clk),
      .reset(reset),
      .load_i(pc_load),
      .inc_i(pc_inc),
      .target_i(pc_tgt),
      .pc_o(pc)
   );
`ifdef FETCH_STATS_EN
   logic [31:0] cnt_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else if (fill & ~bus.flush) cnt_q <= cnt_q + 32'd1;
   assign fetch_count = cnt_q;
`endif
   assign bus.imem_req = req;
   assign bus.imem_addr = pc;
   assign bus.instr = instr_q;
   assign bus.pc_plus4 = pp4_q;
   assign bus.valid = valid_q;
   assign bus.opcode = instr_q[31:26];
   assign bus.funct = instr_q[5:0];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random traffic checked against a behavioural fetch model.
module tb_fetch_stage;
   logic clk = 1'b0;
   logic reset;
   int n_asrt = 0;
   int n_fail = 0;
   fetch_stage_if bus ();
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
   fetch_stage dut (.clk(clk), .reset(reset), .bus(bus), .fetch_count(fetch_count));
`else
   fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));
`endif
   always #5 clk = ~clk;

   logic [31:0] mem [logic [31:0]];
   // model: running flag, PC, held word, pending redirect, IF/ID contents, delivery count
   bit m_run, m_held, m_pend, m_valid;
   logic [31:0] m_pc, m_hword, m_ptgt, m_instr, m_pp4, m_cnt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : {a[15:0] ^ 16'hA5C3, ~a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_asrt++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_held = 0; m_pend = 0; m_valid = 0;
      m_pc = 0; m_hword = 0; m_ptgt = 0; m_instr = 0; m_pp4 = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      bit out, rd, got;
      logic [31:0] tgt, w;
      out = m_run && !m_held;
      rd = bus.jump || bus.branch_taken;
      tgt = (bus.jump ? bus.jump_target : bus.branch_target) & 32'hFFFF_FFFC;
      got = 0;
      w = 0;
      if (rd) begin
         if (out && !bus.imem_ack) begin m_pend = 1; m_ptgt = tgt; end
         else begin m_pc = tgt; m_held = 0; m_pend = 0; end
      end else if (m_pend) begin
         if (bus.imem_ack) begin m_pc = m_ptgt; m_pend = 0; end
      end else if (m_held) begin
         if (!bus.stall) begin got = 1; w = m_hword; m_held = 0; end
      end else if (out && bus.imem_ack) begin
         if (bus.stall) begin m_held = 1; m_hword = bus.imem_data; end
         else begin got = 1; w = bus.imem_data; end
      end
      if (rd || bus.flush) begin m_instr = 0; m_pp4 = 0; m_valid = 0; end
      else if (got) begin m_instr = w; m_pp4 = m_pc + 4; m_valid = 1; m_cnt++; end
      else if (!bus.stall) begin m_instr = 0; m_pp4 = 0; m_valid = 0; end
      if (got) m_pc = m_pc + 4;
      m_run = 1;
   endtask

   task automatic check_all();
      chk("imem_req", bus.imem_req, m_run && !m_held);
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("instr", bus.instr, m_instr);
      chk("pc_plus4", bus.pc_plus4, m_pp4);
      chk("valid", bus.valid, m_valid);
      chk("opcode", bus.opcode, m_instr >> 26);
      chk("funct", bus.funct, m_instr & 32'h3F);
`ifdef FETCH_STATS_EN
      chk("fetch_count", fetch_count, m_cnt);
`endif
   endtask

   task automatic drive(input logic st, input logic fl, input logic jp, input logic [31:0] jt,
                        input logic br, input logic [31:0] bt, input logic ak);
      bus.stall = st; bus.flush = fl; bus.jump = jp; bus.jump_target = jt;
      bus.branch_taken = br; bus.branch_target = bt; bus.imem_ack = ak;
   endtask

   task automatic tick();
      bus.imem_data = mem_word(bus.imem_addr);
      if (reset) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      bus.imem_data = 0;
      mem[32'h0] = 32'h2008_0005;
      mem[32'h4] = 32'h8D09_0004;
      mem[32'h10] = 32'hDEAD_BEEF;
      model_reset();
      #12;
      check_all();
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      chk("s36_req_rise", bus.imem_req, 1);
      chk("s36_addr0", bus.imem_addr, 32'h0);
      tick();
      chk("s36_instr0", bus.instr, 32'h2008_0005);
      chk("s36_pp4_0", bus.pc_plus4, 32'h4);
      chk("s36_opcode0", bus.opcode, 32'h08);
      chk("s36_addr4", bus.imem_addr, 32'h4);
      tick();
      chk("s36_instr1", bus.instr, 32'h8D09_0004);
      chk("s36_pp4_1", bus.pc_plus4, 32'h8);
      chk("s36_opcode1", bus.opcode, 32'h23);
      chk("s36_addr8", bus.imem_addr, 32'h8);
      drive(1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s37_req_low", bus.imem_req, 0);
         chk("s37_instr_frozen", bus.instr, 32'h8D09_0004);
         chk("s37_pc_held", bus.imem_addr, 32'h8);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("s37_held_word", bus.instr, mem_word(32'h8));
      chk("s37_valid", bus.valid, 1);
      chk("s37_addr12", bus.imem_addr, 32'hC);
      tick();
      chk("s37_once", bus.valid, 0);
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 1, 32'h41, 0, 0, 0);
      tick();
      chk("s38_addr_stable", bus.imem_addr, 32'h10);
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      chk("s38_dropped", bus.instr, 32'h0);
      chk("s38_addr40", bus.imem_addr, 32'h40);
      drive(0, 0, 1, 32'h100, 1, 32'h200, 1);
      tick();
      chk("s39_addr100", bus.imem_addr, 32'h100);
      chk("s39_valid", bus.valid, 0);
      chk("s39_opcode", bus.opcode, 0);
      chk("s39_funct", bus.funct, 0);
      drive(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 1);
      tick();
      chk("s40_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      chk("s40_pp4_wrap", bus.pc_plus4, 32'h0);
      chk("s40_addr_wrap", bus.imem_addr, 32'h0);
      drive(0, 1, 0, 0, 0, 0, 1);
      tick();
      chk("flush_bubble", bus.valid, 0);
      chk("flush_pc_adv", bus.imem_addr, 32'h4);
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 6,
               $urandom, $urandom_range(0, 99) < 6, $urandom, $urandom_range(0, 1) == 1);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("s41_req_outstanding", bus.imem_req, 1);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      tick();
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      chk("s41_stray_ignored", bus.valid, 0);
      chk("s41_restart", bus.imem_addr, 32'h0);
      tick();
      chk("s41_first_word", bus.instr, 32'h2008_0005);
`ifdef FETCH_STATS_EN
      chk("s41_count", fetch_count, 32'h1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Port `clk`, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 Port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 Port `stall`, input, 1 bit: hold the PC and the IF/ID register; driven by the hazard unit.
REQ-004 Port `flush`, input, 1 bit: replace the IF/ID contents with a bubble.
REQ-005 Port `jump`, input, 1 bit: jump redirect request; port `jump_target`, input, 32 bits: its target.
REQ-006 Port `branch_taken`, input, 1 bit: branch redirect request; port `branch_target`, input, 32 bits: its target.
REQ-007 Port `imem_req`, output, 1 bit, and port `imem_addr`, output, 32 bits: instruction-memory request and its address.
REQ-008 Port `imem_ack`, input, 1 bit, and port `imem_data`, input, 32 bits: memory response and its instruction word.
REQ-009 Port `instr`, output, 32 bits: IF/ID instruction; port `pc_plus4`, output, 32 bits: its PC + 4; port `valid`, output, 1 bit: slot holds a real instruction.
REQ-010 Port `opcode`, output, 6 bits: `instr[31:26]`; port `funct`, output, 6 bits: `instr[5:0]`; both feed decode control.

Function
REQ-011 FSM states: FETCH (`imem_req` = 1), HOLD (response captured while stalled, `imem_req` = 0), DISCARD (awaiting the ack of a request cancelled by a redirect).
REQ-012 `imem_addr` and `imem_req` shall be stable while a request is unacknowledged, and `imem_addr` shall equal the PC in FETCH.
REQ-013 FETCH, ack, no stall, no redirect: the IF/ID register loads `imem_data`, `pc_plus4` = PC + 4 and `valid` = 1, and the PC advances by 4; latency is one cycle from ack to `valid`.
REQ-014 FETCH, no ack, no stall: the IF/ID register loads a bubble (`instr` = 0x00000000, `valid` = 0).
REQ-015 FETCH, ack, stall = 1: the word goes to the hold buffer, the PC holds, the IF/ID register holds, and the FSM goes to HOLD.
REQ-016 HOLD, stall = 0: the IF/ID register loads the hold buffer with `valid` = 1, the PC advances by 4, and the FSM goes to FETCH.
REQ-017 Redirect = `jump` OR `branch_taken`; `jump` has priority when both are asserted.
REQ-018 The target's bits [1:0] shall be forced to 0.
REQ-019 Redirect with no outstanding request, or coincident with ack: the PC loads the target, any fetched word is dropped, the IF/ID register loads a bubble, and the FSM goes to FETCH.
REQ-020 Redirect during FETCH without ack: the target is latched and the FSM goes to DISCARD.
REQ-021 In DISCARD, on ack: the data is dropped, the PC loads the latched target, and the FSM goes to FETCH.
REQ-022 A newer redirect arriving in DISCARD overwrites the latched target.
REQ-023 A redirect in HOLD clears the hold buffer and goes to FETCH at the target.
REQ-024 `flush` bubbles the IF/ID register and overrides `stall` for the IF/ID register only; the PC still obeys `stall`.
REQ-025 A redirect overrides `stall`.
REQ-026 PC arithmetic is modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000.
REQ-027 `imem_ack` is ignored whenever `imem_req` = 0 and the FSM is not in DISCARD.

Reset
REQ-028 While `reset` is asserted: PC = `RESET_PC` (0x00000000), FSM = FETCH, `imem_req` = 0, `instr` = 0, `pc_plus4` = 0, `valid` = 0, the hold buffer and latched target are cleared, and the counter is 0.
REQ-029 On the first edge after deassertion, `imem_req` rises with `imem_addr` = `RESET_PC`.
REQ-030 A request outstanding when reset is asserted is abandoned, and its late ack is ignored per REQ-027.

Configuration
REQ-031 With `FETCH_STATS_EN` defined, the block adds output port `fetch_count` (32 bits), which increments on every REQ-013/REQ-016 load with `valid` = 1 and wraps modulo 2^32.
REQ-032 With `FETCH_STATS_EN` undefined, the `fetch_count` port and its counter are absent, and all other behaviour is identical.

Structure
REQ-033 The shared definitions header holds `RESET_PC`, `NOP_INSTR` (0x00000000), the 32-bit word width and the FSM state encodings.
REQ-034 The sub-module `pc_reg` holds the PC with async reset, hold, +4 and target load.
REQ-035 The FSM, the hold buffer and the IF/ID register live in `fetch_stage`.

Verification
REQ-036 Scenario: release reset with an ack on every cycle; `instr` = 0x20080005, 0x8D090004 at PC 0 and 4 -> `imem_addr` 0, 4, 8; `pc_plus4` 4, 8; `opcode` 0x08, then 0x23.
REQ-037 Scenario: ack at PC 8 with `stall` high for 3 cycles -> `imem_req` low, `valid`/`instr` frozen, PC = 8; when stall drops, the held word appears once and `imem_addr` = 12.
REQ-038 Scenario: `jump` with target 0x00000041 during an unacked request at PC 0x10 -> DISCARD; the next ack's data is never seen on `instr`; the following `imem_addr` = 0x40.
REQ-039 Scenario: `jump` to 0x100 and `branch_taken` to 0x200 in the same cycle -> the next `imem_addr` = 0x100; the IF/ID register is a bubble (`valid` = 0, `opcode` = 0, `funct` = 0).
REQ-040 Scenario: PC = 0xFFFFFFFC with an ack -> `pc_plus4` = 0x00000000 and the next `imem_addr` = 0x00000000.
REQ-041 Scenario: assert `reset` mid-request, then a stray ack -> all outputs are 0, the stray ack is ignored, and fetch restarts at 0x00000000; with `FETCH_STATS_EN` defined, `fetch_count` = 0.
